// File: rtl/vu_queue_pkg.sv
// Shared defaults and width helpers for the vector-unit command/immediate issue queues.
package vu_queue_pkg;
    localparam int CMD_W_DEF       = 20;
    localparam int XIMM_W_DEF      = 64;
    localparam int CMDQ_DEPTH_DEF  = 4;
    localparam int XIMMQ_DEPTH_DEF = 4;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/vu_fifo.sv
// Power-of-two circular FIFO with separate occupancy count.
// VU_QUEUE_BYPASS_EN: an empty queue forwards a push straight to a ready consumer.
module vu_fifo
    import vu_queue_pkg::*;
#(
    parameter int W     = CMD_W_DEF,
    parameter int DEPTH = CMDQ_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [W-1:0]              push_bits,
    input  logic                      deq_ready,
    output logic                      deq_valid,
    output logic [W-1:0]              deq_bits,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] cnt;
    logic          empty, bypass, do_push, do_pop;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    assign count = cnt;

`ifdef VU_QUEUE_BYPASS_EN
    // Forwarded entries are consumed in the same cycle and never stored.
    assign bypass    = push && empty && deq_ready;
    assign deq_valid = !empty || bypass;
    assign deq_bits  = empty ? push_bits : mem[head];
`else
    assign bypass    = 1'b0;
    assign deq_valid = !empty;
    assign deq_bits  = mem[head];
`endif

    assign do_push = push && !full && !bypass;
    assign do_pop  = !empty && deq_ready;

    // Storage is deliberately left unreset; the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[tail] <= push_bits;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (do_push)
                tail <= tail + PW'(1);
            if (do_pop)
                head <= head + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/vu_cmd_ximm_queues.sv
// Decoder-side issue stage: atomically enqueues into cmdq and/or ximm1q, replaying when a target is full.
// VU_QUEUE_BYPASS_EN enables same-cycle forwarding through empty queues.
module vu_cmd_ximm_queues
    import vu_queue_pkg::*;
#(
    parameter int CMD_W       = CMD_W_DEF,
    parameter int XIMM_W      = XIMM_W_DEF,
    parameter int CMDQ_DEPTH  = CMDQ_DEPTH_DEF,
    parameter int XIMMQ_DEPTH = XIMMQ_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          io_valid,
    input  logic                          io_sigs_enq_cmdq,
    input  logic                          io_sigs_enq_ximm1q,
    input  logic [CMD_W-1:0]              io_cmd_bits,
    input  logic [XIMM_W-1:0]             io_ximm1_bits,
    output logic                          io_replay,
    output logic                          io_fire,
    output logic                          io_cmdq_deq_valid,
    input  logic                          io_cmdq_deq_ready,
    output logic [CMD_W-1:0]              io_cmdq_deq_bits,
    output logic                          io_ximm1q_deq_valid,
    input  logic                          io_ximm1q_deq_ready,
    output logic [XIMM_W-1:0]             io_ximm1q_deq_bits,
    output logic [$clog2(CMDQ_DEPTH):0]   io_cmdq_count,
    output logic [$clog2(XIMMQ_DEPTH):0]  io_ximm1q_count
);
    logic cmdq_full, ximm1q_full;

    // Space comes from registered counts only, so deq_ready never reaches replay.
    assign io_replay = io_valid && (!reset ||
                                    (io_sigs_enq_cmdq   && cmdq_full) ||
                                    (io_sigs_enq_ximm1q && ximm1q_full));
    assign io_fire   = io_valid && !io_replay;

    vu_fifo #(.W(CMD_W), .DEPTH(CMDQ_DEPTH)) u_cmdq (
        .clk       (clk),
        .reset     (reset),
        .push      (io_fire && io_sigs_enq_cmdq),
        .push_bits (io_cmd_bits),
        .deq_ready (io_cmdq_deq_ready),
        .deq_valid (io_cmdq_deq_valid),
        .deq_bits  (io_cmdq_deq_bits),
        .full      (cmdq_full),
        .count     (io_cmdq_count)
    );

    vu_fifo #(.W(XIMM_W), .DEPTH(XIMMQ_DEPTH)) u_ximm1q (
        .clk       (clk),
        .reset     (reset),
        .push      (io_fire && io_sigs_enq_ximm1q),
        .push_bits (io_ximm1_bits),
        .deq_ready (io_ximm1q_deq_ready),
        .deq_valid (io_ximm1q_deq_valid),
        .deq_bits  (io_ximm1q_deq_bits),
        .full      (ximm1q_full),
        .count     (io_ximm1q_count)
    );
endmodule

// File: tb/tb_vu_cmd_ximm_queues.sv
// Directed vector bench for vu_cmd_ximm_queues (default depths 4/4).
module tb_vu_cmd_ximm_queues;
    logic        clk = 1'b0;
    logic        reset;
    logic        io_valid, io_sigs_enq_cmdq, io_sigs_enq_ximm1q;
    logic [19:0] io_cmd_bits;
    logic [63:0] io_ximm1_bits;
    logic        io_replay, io_fire;
    logic        io_cmdq_deq_valid, io_cmdq_deq_ready;
    logic [19:0] io_cmdq_deq_bits;
    logic        io_ximm1q_deq_valid, io_ximm1q_deq_ready;
    logic [63:0] io_ximm1q_deq_bits;
    logic [2:0]  io_cmdq_count, io_ximm1q_count;

    int passed = 0;
    int total  = 0;

    vu_cmd_ximm_queues dut (
        .clk(clk), .reset(reset),
        .io_valid(io_valid), .io_sigs_enq_cmdq(io_sigs_enq_cmdq), .io_sigs_enq_ximm1q(io_sigs_enq_ximm1q),
        .io_cmd_bits(io_cmd_bits), .io_ximm1_bits(io_ximm1_bits),
        .io_replay(io_replay), .io_fire(io_fire),
        .io_cmdq_deq_valid(io_cmdq_deq_valid), .io_cmdq_deq_ready(io_cmdq_deq_ready), .io_cmdq_deq_bits(io_cmdq_deq_bits),
        .io_ximm1q_deq_valid(io_ximm1q_deq_valid), .io_ximm1q_deq_ready(io_ximm1q_deq_ready), .io_ximm1q_deq_bits(io_ximm1q_deq_bits),
        .io_cmdq_count(io_cmdq_count), .io_ximm1q_count(io_ximm1q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v, ec, ex; logic [19:0] cmd; logic [63:0] xi; logic cr, xr;
        logic f, r, cv; logic [19:0] cb; logic xv; logic [63:0] xb; int cc, xc;
    } vec_t;
    vec_t vecs[14];
    logic [63:0] xmodel[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic v, ec, ex, input logic [19:0] cmd, input logic [63:0] xi, input logic cr, xr);
        io_valid = v; io_sigs_enq_cmdq = ec; io_sigs_enq_ximm1q = ex;
        io_cmd_bits = cmd; io_ximm1_bits = xi;
        io_cmdq_deq_ready = cr; io_ximm1q_deq_ready = xr;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(0, 0, 0, '0, '0, 0, 0);
        next_cycle(); next_cycle();
        reset = 1'b1;
    endtask

    initial begin
        // {v,ec,ex,cmd,xi,cr,xr | fire,replay,cv,cb,xv,xb,cc,xc}
        vecs[0]  = '{1,1,1,20'h00ABC,64'h1234,0,0, 1,0,0,20'h0,    0,64'h0,   0,0};
        vecs[1]  = '{0,0,0,20'h0,    64'h0,   0,0, 0,0,1,20'h00ABC,1,64'h1234,1,1};
        vecs[2]  = '{1,1,0,20'h00001,64'h0,   0,0, 1,0,1,20'h00ABC,1,64'h1234,1,1};
        vecs[3]  = '{1,1,0,20'h00002,64'h0,   0,0, 1,0,1,20'h00ABC,1,64'h1234,2,1};
        vecs[4]  = '{1,1,0,20'h00003,64'h0,   0,0, 1,0,1,20'h00ABC,1,64'h1234,3,1};
        vecs[5]  = '{1,1,1,20'h00004,64'h5555,0,0, 0,1,1,20'h00ABC,1,64'h1234,4,1};
        vecs[6]  = '{1,0,1,20'h0,    64'h6666,0,0, 1,0,1,20'h00ABC,1,64'h1234,4,1};
        vecs[7]  = '{1,1,0,20'h00005,64'h0,   1,0, 0,1,1,20'h00ABC,1,64'h1234,4,2};
        vecs[8]  = '{1,1,0,20'h00005,64'h0,   0,0, 1,0,1,20'h00001,1,64'h1234,3,2};
        vecs[9]  = '{1,0,0,20'h0,    64'h0,   1,1, 1,0,1,20'h00001,1,64'h1234,4,2};
        vecs[10] = '{0,0,0,20'h0,    64'h0,   1,1, 0,0,1,20'h00002,1,64'h6666,3,1};
        vecs[11] = '{0,0,0,20'h0,    64'h0,   1,0, 0,0,1,20'h00003,0,64'h0,   2,0};
        vecs[12] = '{0,0,0,20'h0,    64'h0,   1,0, 0,0,1,20'h00005,0,64'h0,   1,0};
        vecs[13] = '{0,0,0,20'h0,    64'h0,   0,0, 0,0,0,20'h0,    0,64'h0,   0,0};

        // Reset behaviour: valid held high must replay, nothing fires.
        reset = 1'b0;
        drive(1, 1, 1, 20'h11111, 64'h22, 1, 1);
        @(negedge clk);
        chk("rst_replay", io_replay, 1);
        chk("rst_fire", io_fire, 0);
        next_cycle();
        @(negedge clk);
        chk("rst_cmdq_count", io_cmdq_count, 0);
        chk("rst_ximm_count", io_ximm1q_count, 0);
        chk("rst_cmdq_valid", io_cmdq_deq_valid, 0);
        chk("rst_ximm_valid", io_ximm1q_deq_valid, 0);
        next_cycle();
        drive(0, 0, 0, '0, '0, 0, 0);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].ec, vecs[i].ex, vecs[i].cmd, vecs[i].xi, vecs[i].cr, vecs[i].xr);
            @(negedge clk);
            chk($sformatf("v%0d_fire", i), io_fire, vecs[i].f);
            chk($sformatf("v%0d_replay", i), io_replay, vecs[i].r);
            chk($sformatf("v%0d_cmdq_valid", i), io_cmdq_deq_valid, vecs[i].cv);
            chk($sformatf("v%0d_ximm_valid", i), io_ximm1q_deq_valid, vecs[i].xv);
            chk($sformatf("v%0d_cmdq_count", i), io_cmdq_count, vecs[i].cc);
            chk($sformatf("v%0d_ximm_count", i), io_ximm1q_count, vecs[i].xc);
            if (vecs[i].cv) chk($sformatf("v%0d_cmdq_bits", i), io_cmdq_deq_bits, vecs[i].cb);
            if (vecs[i].xv) chk($sformatf("v%0d_ximm_bits", i), io_ximm1q_deq_bits, vecs[i].xb);
            next_cycle();
        end

        // ximm1q pointer wrap: 6 pushes interleaved with 4 pops.
        do_reset();
        xmodel.delete();
        for (int i = 0; i < 6; i++) begin
            logic pop;
            pop = (i >= 2);
            drive(1, 0, 1, '0, 64'h100 + 64'(i), 0, pop);
            @(negedge clk);
            chk($sformatf("wrap%0d_fire", i), io_fire, 1);
            if (pop) begin
                chk($sformatf("wrap%0d_valid", i), io_ximm1q_deq_valid, 1);
                chk($sformatf("wrap%0d_bits", i), io_ximm1q_deq_bits, xmodel[0]);
            end
            next_cycle();
            xmodel.push_back(64'h100 + 64'(i));
            if (pop) void'(xmodel.pop_front());
        end
        drive(0, 0, 0, '0, '0, 0, 1);
        @(negedge clk);
        chk("wrap_final_count", io_ximm1q_count, 2);
        chk("wrap_drain0", io_ximm1q_deq_bits, 64'h104);
        next_cycle();
        @(negedge clk);
        chk("wrap_drain1", io_ximm1q_deq_bits, 64'h105);
        next_cycle();
        @(negedge clk);
        chk("wrap_empty", io_ximm1q_deq_valid, 0);

        // Mid-operation reset discards queued entries.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 20'h00010 + 20'(i), 64'h20 + 64'(i), 0, 0);
            next_cycle();
        end
        reset = 1'b0;
        drive(1, 1, 0, 20'h000FF, '0, 0, 0);
        @(negedge clk);
        chk("midrst_replay", io_replay, 1);
        chk("midrst_fire", io_fire, 0);
        next_cycle();
        reset = 1'b1;
        drive(0, 0, 0, '0, '0, 0, 0);
        @(negedge clk);
        chk("midrst_cmdq_count", io_cmdq_count, 0);
        chk("midrst_ximm_count", io_ximm1q_count, 0);
        chk("midrst_cmdq_valid", io_cmdq_deq_valid, 0);
        chk("midrst_ximm_valid", io_ximm1q_deq_valid, 0);
        next_cycle();

        // Push into empty cmdq with consumer ready.
        drive(1, 1, 0, 20'h00777, '0, 1, 0);
        @(negedge clk);
`ifdef VU_QUEUE_BYPASS_EN
        chk("byp_valid", io_cmdq_deq_valid, 1);
        chk("byp_bits", io_cmdq_deq_bits, 20'h00777);
        next_cycle();
        drive(0, 0, 0, '0, '0, 1, 0);
        @(negedge clk);
        chk("byp_count", io_cmdq_count, 0);
        chk("byp_after_valid", io_cmdq_deq_valid, 0);
`else
        chk("nobyp_valid", io_cmdq_deq_valid, 0);
        next_cycle();
        drive(0, 0, 0, '0, '0, 1, 0);
        @(negedge clk);
        chk("nobyp_count", io_cmdq_count, 1);
        chk("nobyp_valid_next", io_cmdq_deq_valid, 1);
        chk("nobyp_bits", io_cmdq_deq_bits, 20'h00777);
`endif
        next_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
